// File: rtl/muxn_pkg.sv
// Shared definitions for the muxn_rr channel multiplexer: width helper,
// grant-mode constants and the output register state encoding.
package muxn_pkg;

  localparam int MUXN_MODE_SEL = 0;
  localparam int MUXN_MODE_RR  = 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/muxn_rr_if.sv
// Channel-side and output-side signals of muxn_rr, grouped with
// master (producer/consumer side) and slave (muxn_rr side) modports.
interface muxn_rr_if
  import muxn_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) ();
  localparam int SELW = clog2(CHANNELS);

  logic [SELW-1:0]           sel;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_ready;
  logic                      out_valid;
  logic [WIDTH-1:0]          out_data;
  logic [SELW-1:0]           out_chan;
  logic                      out_ready;
  logic [15:0]               xfer_cnt;

  modport slave (
    input  sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan, xfer_cnt
  );

  modport master (
    output sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan, xfer_cnt
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester found searching upward
// from last+1, wrapping modulo CHANNELS. One-hot or zero grant.
module rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int SELW     = 2
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SELW-1:0]     last,
  output logic [CHANNELS-1:0] gnt
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int d = 1; d <= CHANNELS; d++) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (!found && req[k] && (((int'(last) + d) % CHANNELS) == k)) begin
          gnt[k] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/muxn_rr.sv
// N-channel multiplexer into a one-deep output register; explicit-select or
// round-robin grant. Optional transfer counter under MUXN_RR_XFER_CNT_EN.
//
// state    | meaning
// ST_EMPTY | output register holds no word, out_valid=0
// ST_FULL  | output register holds a word, out_valid=1
module muxn_rr
  import muxn_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int MODE     = MUXN_MODE_SEL
) (
  input  logic     clk,
  input  logic     rst_n,
  muxn_rr_if.slave bus
);
  localparam int SELW = clog2(CHANNELS);

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0]     out_chan_q, out_chan_d;
  logic [CHANNELS-1:0] gnt;
  logic [SELW-1:0]     gnt_idx;
  logic [WIDTH-1:0]    gnt_word;
  logic                can_load;
  logic                load;

  // rst_n gates the grant so in_ready stays low for the whole reset pulse
  assign can_load     = rst_n && ((state_q == ST_EMPTY) || bus.out_ready);
  assign bus.in_ready = can_load ? gnt : '0;
  assign load         = |bus.in_ready;

  generate
    if (MODE == MUXN_MODE_RR) begin : g_rr
      logic [SELW-1:0] last_q, last_d;
      logic            unused_sel;

      assign unused_sel = ^bus.sel;

      always_comb last_d = load ? gnt_idx : last_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= SELW'(CHANNELS - 1);
        else        last_q <= last_d;
      end

      rr_arbiter #(.CHANNELS(CHANNELS), .SELW(SELW)) u_arb (
        .req  (bus.in_valid),
        .last (last_q),
        .gnt  (gnt)
      );
    end else begin : g_sel
      // an out-of-range sel matches no k, so nothing is granted
      always_comb begin
        gnt = '0;
        for (int k = 0; k < CHANNELS; k++) begin
          if ({1'b0, bus.sel} == (SELW + 1)'(k)) gnt[k] = bus.in_valid[k];
        end
      end
    end
  endgenerate

  always_comb begin
    gnt_idx  = '0;
    gnt_word = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (gnt[k]) begin
        gnt_idx  = SELW'(k);
        gnt_word = bus.in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_chan_d = out_chan_q;
    case (state_q)
      ST_EMPTY: if (load) state_d = ST_FULL;
      ST_FULL:  if (bus.out_ready && !load) state_d = ST_EMPTY;
    endcase
    if (load) begin
      out_data_d = gnt_word;
      out_chan_d = gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      out_chan_q <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_chan_q <= out_chan_d;
    end
  end

  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;

`ifdef MUXN_RR_XFER_CNT_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if ((state_q == ST_FULL) && bus.out_ready) xfer_cnt_d = xfer_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) xfer_cnt_q <= '0;
    else        xfer_cnt_q <= xfer_cnt_d;
  end

  assign bus.xfer_cnt = xfer_cnt_q;
`else
  assign bus.xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_muxn_rr.sv
// Bench for muxn_rr: one select-mode and one round-robin instance share
// stimulus and are compared against a behavioural model each cycle.
module tb_muxn_rr;
  localparam int W  = 8;
  localparam int CH = 4;
`ifdef MUXN_RR_XFER_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic [1:0]    sel_v;
  logic [CH-1:0] valid_v;
  logic [31:0]   data_v;
  logic          ordy_v;

  int checks;
  int errors;

  int mv[2];
  int md[2];
  int mc[2];
  int ml[2];
  int mcnt[2];
  int g[2];

  muxn_rr_if #(.WIDTH(W), .CHANNELS(CH)) b0 ();
  muxn_rr_if #(.WIDTH(W), .CHANNELS(CH)) b1 ();

  assign b0.sel = sel_v;  assign b0.in_valid = valid_v;
  assign b0.in_data = data_v;  assign b0.out_ready = ordy_v;
  assign b1.sel = sel_v;  assign b1.in_valid = valid_v;
  assign b1.in_data = data_v;  assign b1.out_ready = ordy_v;

  muxn_rr #(.WIDTH(W), .CHANNELS(CH), .MODE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  muxn_rr #(.WIDTH(W), .CHANNELS(CH), .MODE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int s, input int v, input logic [31:0] d, input bit r);
    sel_v   = 2'(s);
    valid_v = CH'(v);
    data_v  = d;
    ordy_v  = r;
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mv[m] = 0; md[m] = 0; mc[m] = 0; ml[m] = CH - 1; mcnt[m] = 0;
    end
  endtask

  // Channel the spec's rules pick this cycle, or -1 for none
  function automatic int grant_of(input int m);
    if (!rst_n) return -1;
    if (mv[m] == 1 && !ordy_v) return -1;
    if (m == 0) begin
      if (int'(sel_v) < CH && valid_v[sel_v]) return int'(sel_v);
      return -1;
    end
    for (int d = 1; d <= CH; d++) begin
      if (valid_v[(ml[m] + d) % CH]) return (ml[m] + d) % CH;
    end
    return -1;
  endfunction

  task automatic model_edge(input int m);
    if (!rst_n) begin
      mv[m] = 0; md[m] = 0; mc[m] = 0; ml[m] = CH - 1; mcnt[m] = 0;
    end else begin
      if (mv[m] == 1 && ordy_v) mcnt[m] = (mcnt[m] + 1) % 65536;
      if (g[m] >= 0) begin
        mv[m] = 1;
        md[m] = int'((data_v >> (g[m] * W)) & 32'hFF);
        mc[m] = g[m];
        ml[m] = g[m];
      end else if (mv[m] == 1 && ordy_v) begin
        mv[m] = 0;
      end
    end
  endtask

  task automatic chk_outputs();
    chk("m0_out_valid", 32'(b0.out_valid), mv[0]);
    chk("m0_out_data",  32'(b0.out_data),  md[0]);
    chk("m0_out_chan",  32'(b0.out_chan),  mc[0]);
    chk("m0_xfer_cnt",  32'(b0.xfer_cnt),  CNT_EN ? mcnt[0] : 0);
    chk("m1_out_valid", 32'(b1.out_valid), mv[1]);
    chk("m1_out_data",  32'(b1.out_data),  md[1]);
    chk("m1_out_chan",  32'(b1.out_chan),  mc[1]);
    chk("m1_xfer_cnt",  32'(b1.xfer_cnt),  CNT_EN ? mcnt[1] : 0);
  endtask

  // Called at posedge+1 with inputs already applied; returns at next posedge+1
  task automatic cycle();
    #1;
    for (int m = 0; m < 2; m++) g[m] = grant_of(m);
    chk("m0_in_ready", 32'(b0.in_ready), (g[0] >= 0) ? (1 << g[0]) : 0);
    chk("m1_in_ready", 32'(b1.in_ready), (g[1] >= 0) ? (1 << g[1]) : 0);
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) model_edge(m);
    chk_outputs();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_outputs();
    drive(0, 4'hF, 32'h1234_5678, 1'b1);
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(0, 0, 32'h0, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    drive(0, 4'hF, 32'hDEAD_BEEF, 1'b1);
    #1;
    chk("rst_in_ready0", 32'(b0.in_ready), 0);
    chk("rst_in_ready1", 32'(b1.in_ready), 0);
    chk_outputs();
    cycle();
    rst_n = 1'b1;

    // explicit select of channel 2
    drive(2, 4'b0100, 32'h00A5_0000, 1'b1);
    #1;
    chk("sel2_in_ready", 32'(b0.in_ready), 32'h4);
    cycle();
    chk("sel2_out_valid", 32'(b0.out_valid), 1);
    chk("sel2_out_data", 32'(b0.out_data), 32'hA5);
    chk("sel2_out_chan", 32'(b0.out_chan), 2);

    // selected channel idle while another is valid
    drive(3, 4'b0001, 32'h0000_0077, 1'b1);
    #1;
    chk("sel3_in_ready", 32'(b0.in_ready), 0);
    cycle();
    chk("sel3_out_valid", 32'(b0.out_valid), 0);

    // round-robin rotation from reset
    apply_reset();
    drive(0, 4'hF, 32'h4433_2211, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("rr_seq_chan", 32'(b1.out_chan), i % 4);
      chk("rr_seq_valid", 32'(b1.out_valid), 1);
    end

    // backpressure hold then resume
    drive(0, 0, 32'h0, 1'b1);
    cycle();
    drive(1, 4'b0010, 32'h0000_1100, 1'b0);
    cycle();
    chk("bp_load", 32'(b0.out_data), 32'h11);
    for (int i = 0; i < 3; i++) begin
      drive(i, 4'hF, $urandom, 1'b0);
      #1;
      chk("bp_in_ready", 32'(b0.in_ready), 0);
      cycle();
      chk("bp_hold_data", 32'(b0.out_data), 32'h11);
      chk("bp_hold_chan", 32'(b0.out_chan), 1);
    end
    drive(2, 4'b0100, 32'h0033_0000, 1'b1);
    cycle();
    chk("bp_resume_data", 32'(b0.out_data), 32'h33);
    chk("bp_resume_valid", 32'(b0.out_valid), 1);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3), $urandom_range(0, 15), $urandom,
            ($urandom_range(0, 3) != 0));
      cycle();
    end

    // reset asserted at the same edge as a load while full
    drive(0, 0, 32'h0, 1'b1);
    cycle();
    drive(1, 4'b0010, 32'h0000_5500, 1'b1);
    cycle();
    drive(1, 4'b0010, 32'h0000_6600, 1'b1);
    @(posedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_valid0", 32'(b0.out_valid), 0);
    chk("async_rst_valid1", 32'(b1.out_valid), 0);
    chk_outputs();
    drive(0, 4'hF, 32'h8877_6655, 1'b1);
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("post_rst_rr_chan", 32'(b1.out_chan), 0);
    chk("post_rst_rr_valid", 32'(b1.out_valid), 1);

    // 65537 handshakes: counter wraps to 1 when built, else stays 0
    apply_reset();
    drive(0, 4'hF, 32'hCAFE_F00D, 1'b1);
    for (int i = 0; i < 65538; i++) cycle();
    chk("xfer_wrap1", 32'(b1.xfer_cnt), CNT_EN ? 1 : 0);
    chk("xfer_wrap0", 32'(b0.xfer_cnt), CNT_EN ? 1 : 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muxn_rr.md
MUXN_RR -- requirements
Module: muxn_rr

Interface
REQ-001 Parameter WIDTH, default 8, data width per channel.
REQ-002 Parameter CHANNELS, default 4, number of input channels, legal range 2..16.
REQ-003 Parameter MODE, default 0, selects the grant mode: 0 = explicit select, 1 = round-robin.
REQ-004 SELW SHALL be a derived localparam equal to clog2(CHANNELS).
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 sel  input  SELW  requested channel; used only when MODE=0.
REQ-008 in_valid  input  CHANNELS  per-channel data-valid.
REQ-009 in_data  input  CHANNELS*WIDTH  flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 in_ready  output  CHANNELS  one-hot; bit k high means channel k is accepted this cycle.
REQ-011 out_valid  output  1  the output register holds a word.
REQ-012 out_data  output  WIDTH  registered selected word.
REQ-013 out_chan  output  SELW  index of the channel that supplied out_data.
REQ-014 out_ready  input  1  downstream accepts the word.
REQ-015 xfer_cnt  output  16  count of completed output transfers (see Configuration).

Function
REQ-016 A one-deep output register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 The block can load when in state EMPTY, or when in state FULL and out_valid&out_ready is high in the same cycle (pass-through at full throughput).
REQ-018 MODE=0 grant: channel sel, only when in_valid[sel]=1; no other channel is ever granted.
REQ-019 MODE=0: sel >= CHANNELS grants nothing, and in_ready stays all-zero.
REQ-020 MODE=1 grant: the first valid channel searching upward from (last_grant+1) mod CHANNELS, wrapping around.
REQ-021 MODE=1: last_grant updates only on an accepted load; last_grant resets to CHANNELS-1, so channel 0 has first priority.
REQ-022 in_ready SHALL be combinational and one-hot or zero; it is high only for the granted channel and only when the block can load.
REQ-023 Load: out_data <= the granted word and out_chan <= the granted index, on the edge where in_valid&in_ready is high; out_valid=1 on the next cycle (latency 1).
REQ-024 Drain without load: FULL -> EMPTY.
REQ-025 Simultaneous drain and load: the state stays FULL and the new word replaces the old word with no bubble.
REQ-026 While FULL and out_ready=0: out_data and out_chan are held stable, in_ready is all-zero, and a change of sel has no effect.
REQ-027 With no valid channel granted, the state and the data registers are unchanged.

Reset
REQ-028 rst_n low, asynchronously: out_valid=0, out_data=0, out_chan=0, last_grant=CHANNELS-1, xfer_cnt=0, and in_ready=0 for as long as reset is held.
REQ-029 Reset asserted mid-transfer discards the held word; after release the block starts in EMPTY with no residual grant history.

Configuration
REQ-030 Macro MUXN_RR_XFER_CNT_EN, when defined: xfer_cnt increments by 1 on each cycle with out_valid&out_ready, and wraps from 16'hFFFF to 0.
REQ-031 Macro not defined: xfer_cnt is tied to 0, no counter flops are built, and the port list is identical.

Structure
REQ-032 Shared package muxn_pkg holds: the clog2 function, the mode constants MUXN_MODE_SEL=0 and MUXN_MODE_RR=1, and the state encoding constants ST_EMPTY and ST_FULL.
REQ-033 Round-robin grant logic SHALL be the sub-module rr_arbiter (inputs req, last; output one-hot gnt), instantiated only when MODE=1.

Verification
REQ-034 MODE=0, CH=4, W=8: sel=2, in_valid=4'b0100, in_data[2]=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=A5, out_chan=2.
REQ-035 MODE=0: sel=3, in_valid[3]=0, in_valid[0]=1 -> in_ready=0 and out_valid stays 0.
REQ-036 MODE=1: all four in_valid held high, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3 with out_valid=1 every cycle after the first.
REQ-037 Backpressure: load 8'h11, hold out_ready=0 for 3 cycles while in_data changes -> out_data stays 11 and in_ready stays 0; on the first cycle out_ready=1 the next word loads and out_valid stays high.
REQ-038 Assert rst_n low at the same edge as a load with out_valid=1 -> out_valid=0 immediately (asynchronous); after release, MODE=1 grants channel 0 first.
REQ-039 MUXN_RR_XFER_CNT_EN defined: after 65537 handshakes, xfer_cnt=1; undefined: xfer_cnt stays 0 throughout.
